// File: rtl/aes_pkg.sv
// Shared AES types, field-multiply helpers and FSM encoding for the AES datapath blocks.
// No ports. Used by inv_mixcolumn_col and inv_mixcolumns.
package aes_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned COL_W   = 32;
   localparam int unsigned STATE_W = 128;

   typedef logic [BYTE_W-1:0]  byte_t;
   typedef logic [COL_W-1:0]   column_t;
   typedef logic [STATE_W-1:0] state_t;

   // Low byte of the AES reduction polynomial x^8+x^4+x^3+x+1
   localparam byte_t AES_POLY = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } fsm_e;

   // Multiply by x in GF(2^8)
   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic byte_t gmul9(input byte_t b);
      byte_t x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ b;
   endfunction

   function automatic byte_t gmul11(input byte_t b);
      byte_t x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x2 ^ b;
   endfunction

   function automatic byte_t gmul13(input byte_t b);
      byte_t x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   function automatic byte_t gmul14(input byte_t b);
      byte_t x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

endpackage

// File: rtl/inv_mixcolumn_col.sv
// Combinational InvMixColumns on one 32-bit column (row r = bits [8r+7:8r]).
// Ports: col_i  - input column
//        col_o  - transformed column
module inv_mixcolumn_col
   import aes_pkg::*;
(
   input  column_t col_i,
   output column_t col_o
);

   byte_t a0, a1, a2, a3;

   assign a0 = col_i[7:0];
   assign a1 = col_i[15:8];
   assign a2 = col_i[23:16];
   assign a3 = col_i[31:24];

   // Circulant {14,11,13,9} matrix row by row
   assign col_o[7:0]   = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
   assign col_o[15:8]  = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
   assign col_o[23:16] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
   assign col_o[31:24] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);

endmodule

// File: rtl/inv_mixcolumns.sv
// Iterative InvMixColumns(in ^ key) with level-held start/finish handshake.
// Ports: clk           - clock, rising edge
//        rst           - asynchronous reset, active low
//        start         - level request, held until finish is seen
//        in, key       - state and round key, sampled on the capture edge
//        finish        - result valid while start is still high
//        invmixcolumns - result register
// Macro INV_MIXCOLUMNS_UNROLL_EN: four column instances, all columns in one BUSY edge.
module inv_mixcolumns
   import aes_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [STATE_W-1:0] in,
   input  logic [STATE_W-1:0] key,
   output logic               finish,
   output logic [STATE_W-1:0] invmixcolumns
);

   fsm_e        state_q, state_d;
   state_t      work_q, work_d;
   state_t      result_q, result_d;
   logic [1:0]  col_q, col_d;
   logic        finish_q, finish_d;
   logic        last_col;

`ifdef INV_MIXCOLUMNS_UNROLL_EN
   state_t      all_cols;

   // All four columns transformed in parallel
   for (genvar c = 0; c < 4; c++) begin : g_col
      inv_mixcolumn_col u_col (
         .col_i (work_q[c*COL_W +: COL_W]),
         .col_o (all_cols[c*COL_W +: COL_W])
      );
   end

   assign last_col = 1'b1;
`else
   column_t     col_in, col_out;

   // Single shared column instance, column selected by the counter
   assign col_in = work_q[{col_q, 5'd0} +: COL_W];

   inv_mixcolumn_col u_col (
      .col_i (col_in),
      .col_o (col_out)
   );

   assign last_col = (col_q == 2'd3);
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         work_q   <= '0;
         result_q <= '0;
         col_q    <= 2'd0;
         finish_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         result_q <= result_d;
         col_q    <= col_d;
         finish_q <= finish_d;
      end
   end

   // Next-state logic; dropping start anywhere returns to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_BUSY;
         ST_BUSY: begin
            if (!start)        state_d = ST_IDLE;
            else if (last_col) state_d = ST_DONE;
         end
         ST_DONE: if (!start) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      work_d   = work_q;
      result_d = result_q;
      col_d    = col_q;
      finish_d = finish_q;
      unique case (state_q)
         ST_IDLE: begin
            finish_d = 1'b0;
            if (start) begin
               work_d = in ^ key;
               col_d  = 2'd0;
            end
         end
         ST_BUSY: begin
            // Aborting edge writes nothing; earlier columns are kept
            if (start) begin
`ifdef INV_MIXCOLUMNS_UNROLL_EN
               result_d = all_cols;
`else
               result_d[{col_q, 5'd0} +: COL_W] = col_out;
`endif
               col_d = col_q + 2'd1;
               if (last_col) finish_d = 1'b1;
            end
         end
         ST_DONE: if (!start) finish_d = 1'b0;
         default: finish_d = 1'b0;
      endcase
   end

   assign finish        = finish_q;
   assign invmixcolumns = result_q;

endmodule
